// File: rtl/apb_master.sv
// apb_master: valid/ready command port to APB SETUP/ACCESS transfers, one response per command.
// Single outstanding transfer with an optional ACCESS-phase wait timeout.
module apb_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0]         wait_q, wait_d;
    logic                  timeout_hit;

    // Abort on the waiting cycle that brings the count up to TIMEOUT.
    assign timeout_hit = (TIMEOUT > 0) && !PREADY && (wait_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        wait_d        = wait_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = SETUP;
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                wait_d  = '0;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (wait_q != CW'(TIMEOUT)) begin
                    wait_d = wait_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            wait_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            wait_q        <= wait_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Bus controls decode straight from the state register, so reset clears them at once.
    assign cmd_ready   = state_q == IDLE;
    assign PSELx       = state_q != IDLE;
    assign PENABLE     = state_q == ACCESS;
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed vector table plus hand-written timeout, back-to-back and reset sequences.
module tb_apb_master;
    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [3:0] cmd_addr = 4'h0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic [3:0] PADDR;
    logic       PSELx;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic       PREADY = 1'b0;
    logic [7:0] PRDATA = 8'h00;
    logic       PSLVERR = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic       v, w;
        logic [3:0] a;
        logic [7:0] wd;
        logic       rdy;
        logic [7:0] rd;
        logic       serr;
        logic       e_sel, e_en;
        logic [3:0] e_addr;
        logic       e_wr;
        logic [7:0] e_wd;
        logic       e_crdy, e_rv;
        logic [7:0] e_rdata;
        logic       e_rerr, e_rto;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        step();
        cmd_valid = 1'b0;
        step();
    endtask

    initial begin
        int n;
        int acc;
        int rsps;
        logic was_acc;
        // inputs: v w a wd rdy rd serr | expected: sel en addr wr wd crdy rv rdata rerr rto
        tbl[0]  = '{1'b1,1'b1,4'h3,8'hA5,1'b1,8'h00,1'b0, 1'b1,1'b0,4'h3,1'b1,8'hA5,1'b0,1'b0,8'h00,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b1,4'h3,8'hA5,1'b1,8'h00,1'b0, 1'b1,1'b1,4'h3,1'b1,8'hA5,1'b0,1'b0,8'h00,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b0,4'h0,8'h00,1'b1,8'h00,1'b0, 1'b0,1'b0,4'h3,1'b1,8'hA5,1'b1,1'b1,8'h00,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b0,4'h1,8'hFF,1'b0,8'h00,1'b0, 1'b1,1'b0,4'h1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b0,4'h1,8'hFF,1'b0,8'h00,1'b0, 1'b1,1'b1,4'h1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,4'h0,8'h00,1'b0,8'h5C,1'b0, 1'b1,1'b1,4'h1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b0,4'h0,8'h00,1'b0,8'h5C,1'b0, 1'b1,1'b1,4'h1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b0,4'h0,8'h00,1'b0,8'h5C,1'b0, 1'b1,1'b1,4'h1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,4'h0,8'h00,1'b1,8'h5C,1'b0, 1'b0,1'b0,4'h1,1'b0,8'h00,1'b1,1'b1,8'h5C,1'b0,1'b0};
        tbl[9]  = '{1'b1,1'b1,4'h7,8'h3C,1'b1,8'h00,1'b1, 1'b1,1'b0,4'h7,1'b1,8'h3C,1'b0,1'b0,8'h00,1'b0,1'b0};
        tbl[10] = '{1'b0,1'b0,4'h0,8'h00,1'b1,8'h00,1'b1, 1'b1,1'b1,4'h7,1'b1,8'h3C,1'b0,1'b0,8'h00,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b0,4'h0,8'h00,1'b1,8'h00,1'b1, 1'b0,1'b0,4'h7,1'b1,8'h3C,1'b1,1'b1,8'h00,1'b1,1'b0};
        tbl[12] = '{1'b1,1'b0,4'h2,8'hEE,1'b1,8'h99,1'b0, 1'b1,1'b0,4'h2,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b0,4'h0,8'h00,1'b1,8'h99,1'b0, 1'b1,1'b1,4'h2,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0};
        tbl[14] = '{1'b0,1'b0,4'h0,8'h00,1'b1,8'h99,1'b0, 1'b0,1'b0,4'h2,1'b0,8'h00,1'b1,1'b1,8'h99,1'b0,1'b0};
        tbl[15] = '{1'b0,1'b0,4'h0,8'h00,1'b1,8'h99,1'b1, 1'b0,1'b0,4'h2,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0};

        step();
        step();
        chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst psel", 32'(PSELx), 32'd0);
        chk("rst penable", 32'(PENABLE), 32'd0);
        chk("rst paddr", 32'(PADDR), 32'd0);
        chk("rst pwrite", 32'(PWRITE), 32'd0);
        chk("rst pwdata", 32'(PWDATA), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
        PRESETn = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            cmd_valid = tbl[i].v;
            cmd_write = tbl[i].w;
            cmd_addr  = tbl[i].a;
            cmd_wdata = tbl[i].wd;
            PREADY    = tbl[i].rdy;
            PRDATA    = tbl[i].rd;
            PSLVERR   = tbl[i].serr;
            step();
            chk($sformatf("v%0d psel", i), 32'(PSELx), 32'(tbl[i].e_sel));
            chk($sformatf("v%0d penable", i), 32'(PENABLE), 32'(tbl[i].e_en));
            chk($sformatf("v%0d paddr", i), 32'(PADDR), 32'(tbl[i].e_addr));
            chk($sformatf("v%0d pwrite", i), 32'(PWRITE), 32'(tbl[i].e_wr));
            chk($sformatf("v%0d pwdata", i), 32'(PWDATA), 32'(tbl[i].e_wd));
            chk($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(tbl[i].e_crdy));
            chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
            chk($sformatf("v%0d rsp_rdata", i), 32'(rsp_rdata), 32'(tbl[i].e_rdata));
            chk($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(tbl[i].e_rerr));
            chk($sformatf("v%0d rsp_timeout", i), 32'(rsp_timeout), 32'(tbl[i].e_rto));
        end
        PSLVERR = 1'b0;

        // PREADY stuck low: exactly 16 ACCESS cycles, then abort
        PREADY = 1'b0;
        PRDATA = 8'hAA;
        issue(1'b0, 4'h5, 8'h00);
        n = 0;
        while (PENABLE === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("to access cycles", 32'(n), 32'd16);
        chk("to psel", 32'(PSELx), 32'd0);
        chk("to rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to rsp_err", 32'(rsp_err), 32'd1);
        chk("to rsp_timeout", 32'(rsp_timeout), 32'd1);
        chk("to rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("to cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        chk("to rsp_valid drop", 32'(rsp_valid), 32'd0);
        chk("to rsp_timeout drop", 32'(rsp_timeout), 32'd0);

        // PREADY rises on the 16th ACCESS cycle: normal completion
        issue(1'b0, 4'h4, 8'h00);
        for (int k = 0; k < 15; k++) step();
        chk("lim still access", 32'(PENABLE), 32'd1);
        PREADY = 1'b1;
        PRDATA = 8'hC3;
        step();
        chk("lim rsp_valid", 32'(rsp_valid), 32'd1);
        chk("lim rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("lim rsp_err", 32'(rsp_err), 32'd0);
        chk("lim rsp_rdata", 32'(rsp_rdata), 32'hC3);

        // cmd_valid held for 4 writes, zero waits
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'h0;
        cmd_wdata = 8'h10;
        acc = 0;
        rsps = 0;
        for (int c = 0; c < 12; c++) begin
            was_acc = cmd_valid && cmd_ready;
            step();
            if (was_acc) begin
                acc++;
                if (acc < 4) begin
                    cmd_addr  = 4'(acc);
                    cmd_wdata = 8'(8'h10 + acc);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            chk($sformatf("b2b c%0d psel", c), 32'(PSELx), 32'((c % 3) != 2));
            chk($sformatf("b2b c%0d rsp_valid", c), 32'(rsp_valid), 32'((c % 3) == 2));
            if (rsp_valid) begin
                rsps++;
                chk($sformatf("b2b c%0d paddr", c), 32'(PADDR), 32'(c / 3));
            end
        end
        chk("b2b rsp count", 32'(rsps), 32'd4);
        cmd_valid = 1'b0;

        // reset asserted during an ACCESS wait
        PREADY = 1'b0;
        issue(1'b0, 4'h6, 8'h00);
        step();
        step();
        #2 PRESETn = 1'b0;
        #1;
        chk("mid-rst psel", 32'(PSELx), 32'd0);
        chk("mid-rst penable", 32'(PENABLE), 32'd0);
        chk("mid-rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid-rst cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        PRESETn = 1'b1;
        step();
        chk("post-rst rsp_valid", 32'(rsp_valid), 32'd0);
        PREADY = 1'b1;
        PRDATA = 8'h77;
        issue(1'b0, 4'h9, 8'h00);
        step();
        chk("post-rst read valid", 32'(rsp_valid), 32'd1);
        chk("post-rst read rdata", 32'(rsp_rdata), 32'h77);
        chk("post-rst read paddr", 32'(PADDR), 32'h9);
        chk("post-rst read err", 32'(rsp_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
